// File: rtl/uart_temp_rx.sv
// UART 8N1 receiver with 4-byte temperature frame decoder (SYNC, MSB, LSB, CHK).
module uart_temp_rx #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic [15:0] temp_o,
  output logic        temp_valid_o,
  output logic        frame_err_o,
  output logic        chk_err_o,
  output logic        busy_o
);

  localparam int unsigned CW        = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TW        = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TO_CYCLES);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} bit_state_e;
  typedef enum logic [1:0] {FSync, FMsb, FLsb, FChk} frame_state_e;

  logic            rx_meta_q, rx_s_q, rx_prev_q;
  bit_state_e      bit_q, bit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_done, stop_bad, start_det;
  frame_state_e    frame_q, frame_d;
  logic [7:0]      msb_q, msb_d, lsb_q, lsb_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [15:0]     temp_d;
  logic            temp_valid_d, chk_err_d;

  // Two-flop synchronizer plus previous-sample flop for falling-edge detection; idle high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Bit FSM next-state: mid-bit sampling driven by a down-counter.
  always_comb begin
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    start_det = 1'b0;
    unique case (bit_q)
      StIdle: begin
        if (rx_prev_q && !rx_s_q) begin
          start_det = 1'b1;
          cnt_d     = HALF_M1;
          bit_d     = StStart;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            bit_d = StIdle;
          end else begin
            bit_d = StData;
            cnt_d = FULL_M1;
            idx_d = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = FULL_M1;
          if (idx_q == 3'd7) bit_d = StStop;
          else               idx_d = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            byte_done = 1'b1;
            bit_d     = StIdle;
          end else begin
            stop_bad = 1'b1;
            bit_d    = StBreak;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StBreak: begin
        // A held-low line must return high before a new start can be seen.
        if (rx_s_q) bit_d = StIdle;
      end
      default: bit_d = StIdle;
    endcase
  end

  // Frame FSM next-state, advanced by the registered byte pulse; timeout counter.
  always_comb begin
    frame_d      = frame_q;
    msb_d        = msb_q;
    lsb_d        = lsb_q;
    temp_d       = temp_o;
    temp_valid_d = 1'b0;
    chk_err_d    = 1'b0;
    to_cnt_d     = to_cnt_q;
    if (frame_err_o) begin
      frame_d = FSync;
    end else if (rx_valid_o) begin
      unique case (frame_q)
        FSync: if (rx_data_o == SYNC_BYTE) frame_d = FMsb;
        FMsb: begin
          msb_d   = rx_data_o;
          frame_d = FLsb;
        end
        FLsb: begin
          lsb_d   = rx_data_o;
          frame_d = FChk;
        end
        FChk: begin
          if (rx_data_o == (msb_q ^ lsb_q)) begin
            temp_d       = {msb_q, lsb_q};
            temp_valid_d = 1'b1;
          end else begin
            chk_err_d = 1'b1;
          end
          frame_d = FSync;
        end
        default: frame_d = FSync;
      endcase
    end else if (frame_q != FSync && to_cnt_q == TO_LIMIT) begin
      frame_d = FSync;
    end
    // Counts idle line time between bytes of a frame; saturates at the limit.
    if (frame_q == FSync || start_det) begin
      to_cnt_d = '0;
    end else if (bit_q == StIdle && to_cnt_q != TO_LIMIT) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_q        <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      frame_q      <= FSync;
      msb_q        <= '0;
      lsb_q        <= '0;
      to_cnt_q     <= '0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      frame_err_o  <= 1'b0;
      temp_o       <= '0;
      temp_valid_o <= 1'b0;
      chk_err_o    <= 1'b0;
    end else begin
      bit_q        <= bit_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      frame_q      <= frame_d;
      msb_q        <= msb_d;
      lsb_q        <= lsb_d;
      to_cnt_q     <= to_cnt_d;
      rx_valid_o   <= byte_done;
      frame_err_o  <= stop_bad;
      if (byte_done) rx_data_o <= shift_q;
      temp_o       <= temp_d;
      temp_valid_o <= temp_valid_d;
      chk_err_o    <= chk_err_d;
    end
  end

  // Busy output.
  always_comb begin
    busy_o = (bit_q != StIdle) || (frame_q != FSync);
  end

endmodule

// File: tb/tb_uart_temp_rx.sv
// Scoreboard bench for uart_temp_rx: stimulus pushes expected events, a monitor pops them.
module tb_uart_temp_rx;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        uart_rx_i;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic [15:0] temp_o;
  logic        temp_valid_o;
  logic        frame_err_o;
  logic        chk_err_o;
  logic        busy_o;

  uart_temp_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_BITS(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .uart_rx_i   (uart_rx_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .temp_o      (temp_o),
    .temp_valid_o(temp_valid_o),
    .frame_err_o (frame_err_o),
    .chk_err_o   (chk_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Event kinds: 0 byte, 1 temperature, 2 checksum error, 3 framing error
  typedef struct {
    int          kind;
    logic [15:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  // Reference model of the frame layer, in terms of whole bytes.
  int          m_pos  = 0;
  logic [7:0]  m_msb, m_lsb;
  logic [15:0] m_temp = 16'h0;

  function automatic ev_t mk(input int k, input logic [15:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    return e;
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit long_gap);
    if (long_gap) m_pos = 0;  // inter-byte timeout drops a partial frame
    exp_q.push_back(mk(0, {8'h00, b}));
    case (m_pos)
      0: if (b == 8'hA5) m_pos = 1;
      1: begin m_msb = b; m_pos = 2; end
      2: begin m_lsb = b; m_pos = 3; end
      default: begin
        if (b == (m_msb ^ m_lsb)) begin
          m_temp = {m_msb, m_lsb};
          exp_q.push_back(mk(1, m_temp));
        end else begin
          exp_q.push_back(mk(2, m_temp));
        end
        m_pos = 0;
      end
    endcase
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic stop);
    uart_rx_i = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      hold(CPB);
    end
    uart_rx_i = stop;
    hold(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    uart_rx_i = 1'b1;
    hold(gap);
    model_byte(b, gap >= 40);
    drive_byte(b, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] m, input logic [7:0] l, input logic [7:0] c);
    send_byte(8'hA5, 2);
    send_byte(m, 0);
    send_byte(l, 1);
    send_byte(c, 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {7'd0, rx_data_o, rx_valid_o, temp_o, temp_valid_o, frame_err_o, chk_err_o, busy_o},
          32'd0);
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  logic [3:0] pulses;
  ev_t        got;
  ev_t        want;
  always @(negedge clk) begin
    pulses = {frame_err_o, chk_err_o, temp_valid_o, rx_valid_o};
    if (!reset && pulses != 4'b0) begin
      n_checks++;
      if ($countones(pulses) != 1) begin
        n_fail++;
        $display("FAIL pulse_overlap: got pulses %b expected one-hot", pulses);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got pulses %b expected none", pulses);
      end else begin
        want = exp_q.pop_front();
        if (rx_valid_o)        got = mk(0, {8'h00, rx_data_o});
        else if (temp_valid_o) got = mk(1, temp_o);
        else if (chk_err_o)    got = mk(2, temp_o);
        else                   got = mk(3, 16'h0);
        if (got.kind != want.kind || got.data !== want.data) begin
          n_fail++;
          $display("FAIL event: got kind %0d data %h expected kind %0d data %h",
                   got.kind, got.data, want.kind, want.data);
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    uart_rx_i = 1'b1;
    hold(3);
    check_all_zero("reset_outputs");
    reset = 1'b0;
    hold(20);

    // Valid frame
    send_frame(8'h01, 8'h2C, 8'h2D);
    hold(4);
    check("temp_frame1", {16'h0, temp_o}, 32'h012C);

    // Checksum error keeps previous temperature
    send_frame(8'h01, 8'h2C, 8'h00);
    hold(4);
    check("temp_after_chkerr", {16'h0, temp_o}, 32'h012C);

    // Glitch shorter than half a bit
    hold(10);
    uart_rx_i = 1'b0;
    hold(2);
    uart_rx_i = 1'b1;
    hold(8);
    check("glitch_busy", {31'd0, busy_o}, 32'd0);

    // Framing error followed by a held-low line
    hold(5);
    exp_q.push_back(mk(3, 16'h0));
    m_pos = 0;
    drive_byte(8'h5A, 1'b0);
    uart_rx_i = 1'b0;
    hold(40);
    check("break_busy", {31'd0, busy_o}, 32'd1);
    uart_rx_i = 1'b1;
    hold(16);
    send_frame(8'h12, 8'h34, 8'h26);
    hold(4);
    check("temp_after_ferr", {16'h0, temp_o}, 32'h1234);

    // Inter-byte timeout: 2C and 2D must be ignored
    send_byte(8'hA5, 3);
    send_byte(8'h01, 0);
    send_byte(8'h2C, 40);
    send_byte(8'h2D, 0);
    hold(4);
    check("timeout_busy", {31'd0, busy_o}, 32'd0);
    check("timeout_temp", {16'h0, temp_o}, 32'h1234);

    // Reset during the data bits of a frame's second byte (0x01)
    send_byte(8'hA5, 2);
    uart_rx_i = 1'b0;
    hold(CPB);
    uart_rx_i = 1'b1;
    hold(CPB);
    uart_rx_i = 1'b0;
    hold(CPB / 2);
    reset     = 1'b1;
    uart_rx_i = 1'b1;
    m_pos     = 0;
    m_temp    = 16'h0;
    hold(1);
    check_all_zero("midframe_reset_outputs");
    reset = 1'b0;
    hold(3 * CPB);
    check_all_zero("post_reset_idle");
    send_frame(8'h01, 8'h2C, 8'h2D);
    hold(4);
    check("temp_after_reset", {16'h0, temp_o}, 32'h012C);

    // Randomized frames and stray bytes
    for (int i = 0; i < 25; i++) begin
      logic [7:0] m, l, c;
      m = 8'($urandom);
      l = 8'($urandom);
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (m ^ l);
      if ($urandom_range(0, 4) == 0) send_byte(8'($urandom), $urandom_range(0, 12));
      send_byte(8'hA5, $urandom_range(0, 12));
      send_byte(m, $urandom_range(0, 12));
      send_byte(l, $urandom_range(0, 12));
      send_byte(c, $urandom_range(0, 12));
    end
    hold(4);
    check("temp_random_end", {16'h0, temp_o}, {16'h0, m_temp});

    // Drain: every expected event must have been observed
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) hold(1);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
